// File: rtl/instr_fetch_responder.sv
// +-----------------------------------------------------------------------------+
// | Module   : instr_fetch_responder                                            |
// | Purpose  : fixed-latency instruction fetch responder with flush and         |
// |            program-write port                                               |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

module instr_fetch_responder #(
  parameter int DEPTH      = 64,
  parameter int LATENCY    = 2,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  flush,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_instr,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  rsp_fault,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [31:0]           prog_data
);

  localparam int IW         = $clog2(DEPTH);
  localparam int CW         = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int C_CNT_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;

  // RESP is encoded on bit 1 so rsp_valid is a plain flop output
  localparam logic [1:0] C_IDLE = 2'b00;
  localparam logic [1:0] C_WAIT = 2'b01;
  localparam logic [1:0] C_RESP = 2'b10;

  logic [1:0]    r_state;
  logic [1:0]    w_next_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_mem [DEPTH];

  logic w_accept;
  logic w_handshake;
  logic w_req_oor;
  logic w_prog_oor;
  logic w_req_fault;
  logic w_prog_ok;

  // Word index >= DEPTH is equivalent to any address bit above IW+1 being set
  generate
    if (ADDR_WIDTH > IW + 2) begin : g_range_check
      assign w_req_oor  = |req_addr[ADDR_WIDTH-1:IW+2];
      assign w_prog_oor = |prog_addr[ADDR_WIDTH-1:IW+2];
    end else begin : g_no_range_check
      assign w_req_oor  = 1'b0;
      assign w_prog_oor = 1'b0;
    end
  endgenerate

  assign w_req_fault = (req_addr[1:0] != 2'b00) || w_req_oor;
  assign w_prog_ok   = prog_we && (prog_addr[1:0] == 2'b00) && !w_prog_oor;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= C_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      C_IDLE: begin
        if (w_accept) begin
          w_next_state = (LATENCY == 1) ? C_RESP : C_WAIT;
        end
      end
      C_WAIT: begin
        if (flush) begin
          w_next_state = C_IDLE;
        end else if (r_cnt == '0) begin
          w_next_state = C_RESP;
        end
      end
      C_RESP: begin
        // A same-cycle handshake wins over flush; both land in IDLE
        if (w_handshake || flush) begin
          w_next_state = C_IDLE;
        end
      end
      default: w_next_state = C_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = (r_state == C_IDLE) && !flush;
    w_accept    = req_valid && req_ready;
    w_handshake = (r_state == C_RESP) && rsp_ready;
  end

  assign rsp_valid = r_state[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      rsp_instr <= '0;
      rsp_addr  <= '0;
      rsp_fault <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt     <= CW'(C_CNT_INIT);
        rsp_addr  <= req_addr;
        rsp_fault <= w_req_fault;
        rsp_instr <= w_req_fault ? 32'h0 : r_mem[req_addr[IW+1:2]];
      end else if (r_state == C_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Read above samples the pre-write contents, so a colliding write is not seen
  always_ff @(posedge clk) begin
    if (w_prog_ok) begin
      r_mem[prog_addr[IW+1:2]] <= prog_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_responder.sv
// +-----------------------------------------------------------------------------+
// | Module   : tb_instr_fetch_responder                                         |
// | Purpose  : directed self-checking bench for instr_fetch_responder           |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_instr_fetch_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_valid1 = 1'b0;
  logic [31:0] req_addr = '0;
  logic        flush = 1'b0;
  logic        rsp_ready = 1'b1;
  logic        prog_we = 1'b0;
  logic [31:0] prog_addr = '0;
  logic [31:0] prog_data = '0;

  logic        req_ready, rsp_valid, rsp_fault;
  logic [31:0] rsp_instr, rsp_addr;
  logic        req_ready1, rsp_valid1, rsp_fault1;
  logic [31:0] rsp_instr1, rsp_addr1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_fetch_responder #(.DEPTH(64), .LATENCY(2), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .flush(flush),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
    .rsp_addr(rsp_addr), .rsp_fault(rsp_fault),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
  );

  instr_fetch_responder #(.DEPTH(64), .LATENCY(1), .ADDR_WIDTH(32)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr),
    .flush(flush),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr1),
    .rsp_addr(rsp_addr1), .rsp_fault(rsp_fault1),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept at one edge, idle one cycle, response on the second, handshake on the third
  task automatic do_fetch(input string tag, input logic [31:0] addr,
                          input logic [31:0] exp_instr, input logic exp_fault);
    req_addr  = addr;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    chk({tag, "_early"}, 32'(rsp_valid), 32'd0);
    step();
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_instr"}, rsp_instr, exp_instr);
    chk({tag, "_addr"},  rsp_addr, addr);
    chk({tag, "_fault"}, 32'(rsp_fault), 32'(exp_fault));
    step();
    chk({tag, "_drop"},  32'(rsp_valid), 32'd0);
    chk({tag, "_rdy2"},  32'(req_ready), 32'd1);
  endtask

  task automatic prog(input logic [31:0] addr, input logic [31:0] data);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_data = data;
    step();
    prog_we = 1'b0;
  endtask

  initial begin
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_instr", rsp_instr, 32'h0);
    chk("rst_addr",  rsp_addr, 32'h0);
    chk("rst_fault", 32'(rsp_fault), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);

    prog(32'h0, 32'hE3A00001);
    prog(32'h4, 32'hE3A01002);
    prog(32'h8, 32'hE0802001);
    prog(32'hC, 32'hEAFFFFFE);

    do_fetch("f4", 32'h4, 32'hE3A01002, 1'b0);

    // Backpressure: response must hold for 5 cycles
    rsp_ready = 1'b0;
    req_addr  = 32'h8;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_instr", rsp_instr, 32'hE0802001);
      chk("bp_addr",  rsp_addr, 32'h8);
      chk("bp_ready", 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_done", 32'(rsp_valid), 32'd0);

    do_fetch("mis", 32'h6, 32'h0, 1'b1);
    do_fetch("oor", 32'h100, 32'h0, 1'b1);

    // Flush in WAIT
    req_addr  = 32'h0;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    flush     = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk("fw_valid", 32'(rsp_valid), 32'd0);
    chk("fw_ready", 32'(req_ready), 32'd1);
    step();
    chk("fw_never", 32'(rsp_valid), 32'd0);
    do_fetch("fc", 32'hC, 32'hEAFFFFFE, 1'b0);

    // Flush in IDLE blocks acceptance
    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h4;
    #1;
    chk("fi_ready", 32'(req_ready), 32'd0);
    step();
    flush     = 1'b0;
    req_valid = 1'b0;
    step();
    chk("fi_noresp", 32'(rsp_valid), 32'd0);

    // Flush in RESP without handshake
    rsp_ready = 1'b0;
    req_addr  = 32'h4;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    chk("fr_valid", 32'(rsp_valid), 32'd1);
    flush = 1'b1;
    step();
    flush     = 1'b0;
    rsp_ready = 1'b1;
    chk("fr_drop", 32'(rsp_valid), 32'd0);

    // Write and fetch of the same word in one cycle returns the old value
    req_addr  = 32'h0;
    req_valid = 1'b1;
    prog_we   = 1'b1;
    prog_addr = 32'h0;
    prog_data = 32'hDEADBEEF;
    step();
    req_valid = 1'b0;
    prog_we   = 1'b0;
    step();
    chk("wc_valid", 32'(rsp_valid), 32'd1);
    chk("wc_instr", rsp_instr, 32'hE3A00001);
    step();
    do_fetch("wn", 32'h0, 32'hDEADBEEF, 1'b0);

    // Misaligned and out-of-range writes are dropped
    prog(32'h5, 32'h12345678);
    prog(32'h100, 32'h11111111);
    do_fetch("dm", 32'h4, 32'hE3A01002, 1'b0);
    do_fetch("do", 32'h0, 32'hDEADBEEF, 1'b0);

    // Reset in RESP
    rsp_ready = 1'b0;
    req_addr  = 32'h4;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    chk("rr_pre", 32'(rsp_valid), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("rr_valid", 32'(rsp_valid), 32'd0);
    chk("rr_instr", rsp_instr, 32'h0);
    chk("rr_addr",  rsp_addr, 32'h0);
    chk("rr_ready", 32'(req_ready), 32'd1);

    // LATENCY=1 instance: response the cycle right after accept
    req_addr   = 32'h0;
    req_valid1 = 1'b1;
    #1;
    chk("l1_ready", 32'(req_ready1), 32'd1);
    step();
    req_valid1 = 1'b0;
    chk("l1_valid", 32'(rsp_valid1), 32'd1);
    chk("l1_instr", rsp_instr1, 32'hDEADBEEF);
    chk("l1_fault", 32'(rsp_fault1), 32'd0);
    step();
    chk("l1_drop", 32'(rsp_valid1), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/instr_fetch_responder.md
Name: instr_fetch_responder

Overview:
Instruction-memory responder on the fetch side of the core. It accepts fetch requests (word address plus valid/ready) from the program-counter stage and returns the 32-bit instruction word after a fixed, configurable latency. It supports a flush input from branch resolution that cancels any in-flight fetch. Contents are loaded through a program-write port used by the bench and boot logic.

Parameters:
DEPTH, 64, number of 32-bit instruction words; power of two, at least 2; IW = clog2(DEPTH).
LATENCY, 2, cycles from request acceptance to rsp_valid; at least 1.
ADDR_WIDTH, 32, width of the byte address.

Ports:
clk  input  1  clock; all logic is rising-edge.
reset  input  1  synchronous, active-high reset.
req_valid  input  1  fetch request present.
req_ready  output  1  responder can accept a request this cycle.
req_addr  input  ADDR_WIDTH  byte address of the fetch (normally pc).
flush  input  1  cancel any outstanding fetch (branch taken).
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer accepts the response.
rsp_instr  output  32  fetched instruction word.
rsp_addr  output  ADDR_WIDTH  echo of the request address.
rsp_fault  output  1  request was misaligned or out of range.
prog_we  input  1  program-write enable.
prog_addr  input  ADDR_WIDTH  byte address for the program write.
prog_data  input  32  program-write data.

Behaviour:
- Reset:
  - state = IDLE; rsp_valid = 0; rsp_instr = 0; rsp_addr = 0; rsp_fault = 0; counter = 0.
  - Memory array is not cleared.
  - A reset in any state discards the pending fetch.
- States are IDLE, WAIT and RESP.
- req_ready = (state == IDLE) && !flush. It is combinational and does not depend on req_valid.
- Accept happens when req_valid && req_ready at a clock edge. On accept:
  - Latch req_addr into rsp_addr.
  - Evaluate the fault condition: req_addr[1:0] != 0, or the word index req_addr >> 2 is >= DEPTH.
  - On fault: capture instr = 0 and fault = 1. Otherwise capture mem[req_addr[IW+1:2]] and fault = 0.
  - The word is captured at accept. Later program writes to that word do not change the pending response.
- Next state after accept:
  - LATENCY == 1: go to RESP.
  - Otherwise: go to WAIT with counter = LATENCY-2.
- WAIT: decrement the counter each cycle; go to RESP when the counter is 0.
- Timing: rsp_valid rises exactly LATENCY cycles after the accepting edge.
- RESP:
  - rsp_valid = 1; rsp_instr, rsp_addr and rsp_fault hold stable until rsp_valid && rsp_ready.
  - On that handshake, go to IDLE and deassert rsp_valid the next cycle.
  - No new request is accepted in the handshake cycle. Maximum throughput is one fetch per LATENCY+1 cycles.
- flush:
  - In WAIT or RESP without a handshake, the next state is IDLE, rsp_valid = 0 next cycle, and the data is discarded.
  - In RESP with rsp_ready = 1 in the same cycle, the handshake completes (the consumer took the data) and the next state is IDLE.
  - In IDLE, flush blocks acceptance that cycle.
- Program write:
  - If prog_we is high and prog_addr is aligned and in range, write mem[prog_addr[IW+1:2]] = prog_data at the edge.
  - Misaligned or out-of-range writes are silently dropped.
  - Writes are allowed in every state.
  - A write and an accept to the same word in the same cycle: the request returns the old value.
- Other rules:
  - Counter width is clog2(LATENCY) or 1, whichever is larger.
  - Address bits above IW+1 are used only for the range check.
  - Outputs come from registers except req_ready.

Test Plan:
1. Reset, then program words 0..3 with 0xE3A00001, 0xE3A01002, 0xE0802001, 0xEAFFFFFE. Fetch addr 0x4 with LATENCY=2 and rsp_ready=1 -> rsp_valid exactly 2 cycles after accept, rsp_instr=0xE3A01002, rsp_addr=0x4, rsp_fault=0; req_ready high again the cycle after the handshake.
2. Hold rsp_ready=0 for 5 cycles after rsp_valid on a fetch of 0x8 -> rsp_valid, rsp_instr=0xE0802001 and rsp_addr stable all 5 cycles; req_ready=0 throughout; transfer completes when rsp_ready=1.
3. Fetch 0x6 -> rsp_fault=1, rsp_instr=0. Fetch 0x100 with DEPTH=64 -> rsp_fault=1, rsp_instr=0.
4. Accept a fetch of 0x0, assert flush one cycle later (in WAIT) -> rsp_valid never asserts; req_ready=1 the cycle after flush drops; next fetch of 0xC returns 0xEAFFFFFE.
5. Accept a fetch of 0x0 while prog_we writes 0xDEADBEEF to 0x0 in the same cycle -> response is 0xE3A00001; a subsequent fetch of 0x0 returns 0xDEADBEEF.
6. Assert reset while in RESP with rsp_valid=1 -> the next cycle has rsp_valid=0, rsp_instr=0 and req_ready=1. With LATENCY=1 rebuild, a fetch of 0x0 gives rsp_valid on the cycle right after accept.
